// File: rtl/golomb_pkg.sv
// Shared definitions for the Golomb ruler job sequencer: field widths,
// the sequencer state encoding and vector-width helpers.
package golomb_pkg;

  localparam int MARK_W  = 9;
  localparam int POS_W   = 7;
  localparam int NRES_W  = 6;
  localparam int JOBID_W = 8;
  localparam int CYC_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } seq_state_t;

  // Width of one ruler prefix: one MARK_W field per mark, marks 0..num_positions
  function automatic int prefix_width(input int num_positions);
    return (num_positions + 1) * MARK_W;
  endfunction

  // Width of the full result vector: num_results complete rulers
  function automatic int result_width(input int num_positions, input int num_results);
    return prefix_width(num_positions) * num_results;
  endfunction

endpackage

// File: rtl/golomb_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear/enable and a
// terminal-count flag that looks at the value the counter is about to take.
module golomb_cycle_counter
  import golomb_pkg::*;
#(
  parameter logic [CYC_W-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CYC_W-1:0] count_next,
  output logic             terminal
);

  logic [CYC_W-1:0] count;

  // The incremented value sticks at all-ones instead of wrapping
  assign count_next = (count == '1) ? count : count + CYC_W'(1);
  assign terminal   = (count_next >= LIMIT);

  // Counter register: clear wins over enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/golomb_job_sequencer.sv
// Runs one mark_counter_assembly through a stream of host sub-search jobs:
// latch the prefix, pulse the assembly reset, wait for done, and hand the
// tagged result record back over a valid/ready port.
// Optional feature macro: GOLOMB_WATCHDOG_EN (RUN-state cycle limit that
// produces a timeout record when the assembly never signals done).
module golomb_job_sequencer
  import golomb_pkg::*;
#(
  parameter int               MAXVALUE          = 22,
  parameter int               NUMPOSITIONS      = 5,
  parameter int               NUMRESULTS        = 10,
  parameter int               ASSY_RESET_CYCLES = 2,
  parameter logic [CYC_W-1:0] WATCHDOG_CYCLES   = 32'd1000000
) (
  input  logic                                                FXCLK,
  input  logic                                                RESET_IN,
  input  logic                                                job_valid,
  output logic                                                job_ready,
  input  logic [POS_W-1:0]                                    job_firstpos,
  input  logic [prefix_width(NUMPOSITIONS)-1:0]               job_firstvalues,
  output logic                                                assy_reset,
  output logic [POS_W-1:0]                                    assy_firstpos,
  output logic [prefix_width(NUMPOSITIONS)-1:0]               assy_firstvalues,
  input  logic                                                assy_done,
  input  logic [NRES_W-1:0]                                   assy_numResults,
  input  logic [result_width(NUMPOSITIONS, NUMRESULTS)-1:0]   assy_results,
  output logic                                                res_valid,
  input  logic                                                res_ready,
  output logic [JOBID_W-1:0]                                  res_jobid,
  output logic [NRES_W-1:0]                                   res_numResults,
  output logic [result_width(NUMPOSITIONS, NUMRESULTS)-1:0]   res_results,
  output logic [CYC_W-1:0]                                    res_cycles,
  output logic                                                res_timeout,
  output logic                                                busy
);

  localparam int PREFIX_W = prefix_width(NUMPOSITIONS);
  localparam int RESULT_W = result_width(NUMPOSITIONS, NUMRESULTS);

  // Mark positions must fit a mark field and the reset pulse must be non-empty
  if (MAXVALUE >= (1 << MARK_W) || ASSY_RESET_CYCLES < 1 || WATCHDOG_CYCLES == '0) begin : g_bad_params
    $error("golomb_job_sequencer: illegal parameter combination");
  end

  seq_state_t         state;
  seq_state_t         state_next;
  logic               accept;
  logic               capture_done;
  logic               capture_wd;
  logic               handshake;
  logic               run_en;
  logic               wd_hit;
  logic [31:0]        load_cnt;
  logic [JOBID_W-1:0] jobid;
  logic [CYC_W-1:0]   cycles_next;

  assign run_en = (state == RUN);

  golomb_cycle_counter #(
    .LIMIT(WATCHDOG_CYCLES)
  ) u_cycle_counter (
    .clk       (FXCLK),
    .rst       (RESET_IN),
    .clear     (accept),
    .enable    (run_en),
    .count_next(cycles_next),
    .terminal  (wd_hit)
  );

  // State register
  always_ff @(posedge FXCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the handshake and capture strobes
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    capture_done = 1'b0;
    capture_wd   = 1'b0;
    handshake    = 1'b0;
    job_ready    = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        job_ready = !RESET_IN;
        if (job_valid && !RESET_IN) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (load_cnt == 32'(ASSY_RESET_CYCLES - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (assy_done) begin
          capture_done = 1'b1;
          state_next   = REPORT;
        end
`ifdef GOLOMB_WATCHDOG_EN
        else if (wd_hit) begin
          capture_wd = 1'b1;
          state_next = REPORT;
        end
`endif
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifndef GOLOMB_WATCHDOG_EN
  logic unused_wd_hit;
  assign unused_wd_hit = wd_hit;
`endif

  // Job prefix latch, assembly reset pulse and LOAD-phase length counter
  always_ff @(posedge FXCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      assy_reset       <= 1'b1;
      assy_firstpos    <= '0;
      assy_firstvalues <= '0;
      load_cnt         <= '0;
    end else begin
      assy_reset <= (state_next == LOAD);
      if (accept) begin
        assy_firstpos    <= job_firstpos;
        assy_firstvalues <= job_firstvalues;
        load_cnt         <= '0;
      end else if (state == LOAD) begin
        load_cnt <= load_cnt + 32'd1;
      end
    end
  end

  // Result record capture and job tag bookkeeping
  always_ff @(posedge FXCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      jobid          <= '0;
      res_jobid      <= '0;
      res_numResults <= '0;
      res_results    <= '0;
      res_cycles     <= '0;
    end else begin
      if (capture_done || capture_wd) begin
        res_jobid      <= jobid;
        res_cycles     <= cycles_next;
        res_results    <= assy_results;
        res_numResults <= capture_done ? assy_numResults : '0;
      end
      if (handshake) begin
        jobid <= jobid + JOBID_W'(1);
      end
    end
  end

`ifdef GOLOMB_WATCHDOG_EN
  // Timeout flag: done takes priority when it coincides with the limit
  always_ff @(posedge FXCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      res_timeout <= 1'b0;
    end else if (capture_done) begin
      res_timeout <= 1'b0;
    end else if (capture_wd) begin
      res_timeout <= 1'b1;
    end
  end
`else
  assign res_timeout = 1'b0;
`endif

  // Keep the derived widths visible to anyone reading the port list
  logic [PREFIX_W-1:0] unused_prefix_w;
  logic [RESULT_W-1:0] unused_result_w;
  assign unused_prefix_w = assy_firstvalues;
  assign unused_result_w = res_results;

endmodule

// File: tb/tb_golomb_job_sequencer.sv
// Directed bench for golomb_job_sequencer with a bench-driven stand-in for
// the assembly (done/numResults/results). Build with GOLOMB_WATCHDOG_EN
// defined to also exercise the timeout path (limit 64 cycles).
module tb_golomb_job_sequencer;

  localparam int PW = 54;
  localparam int RW = 540;

  localparam logic [PW-1:0] FV_B  = 54'h0_1234_5678_9ABC;
  localparam logic [PW-1:0] FV_C  = 54'h2_0F0F_F0F0_1357;
  localparam logic [PW-1:0] FV_D  = 54'h1_AAAA_5555_0042;
  localparam logic [RW-1:0] PAT_A = {10{54'h1_1111_2222_3333}};
  localparam logic [RW-1:0] PAT_B = {10{54'h2_0A0B_0C0D_0E0F}};
  localparam logic [RW-1:0] PAT_C = {10{54'h3_ABCD_0123_4567}};
  localparam logic [RW-1:0] PAT_D = {10{54'h0_FFFF_0000_AAAA}};
  localparam logic [RW-1:0] PAT_E = {10{54'h1_5555_AAAA_5555}};
  localparam logic [RW-1:0] PAT_F = {10{54'h2_DEAD_BEEF_0001}};

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [6:0]    job_firstpos;
  logic [PW-1:0] job_firstvalues;
  logic          assy_reset;
  logic [6:0]    assy_firstpos;
  logic [PW-1:0] assy_firstvalues;
  logic          assy_done;
  logic [5:0]    assy_numResults;
  logic [RW-1:0] assy_results;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_jobid;
  logic [5:0]    res_numResults;
  logic [RW-1:0] res_results;
  logic [31:0]   res_cycles;
  logic          res_timeout;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int accept_cnt  = 0;

  golomb_job_sequencer #(
    .MAXVALUE         (22),
    .NUMPOSITIONS     (5),
    .NUMRESULTS       (10),
    .ASSY_RESET_CYCLES(2),
    .WATCHDOG_CYCLES  (32'd64)
  ) dut (
    .FXCLK           (clk),
    .RESET_IN        (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_firstpos    (job_firstpos),
    .job_firstvalues (job_firstvalues),
    .assy_reset      (assy_reset),
    .assy_firstpos   (assy_firstpos),
    .assy_firstvalues(assy_firstvalues),
    .assy_done       (assy_done),
    .assy_numResults (assy_numResults),
    .assy_results    (assy_results),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_jobid       (res_jobid),
    .res_numResults  (res_numResults),
    .res_results     (res_results),
    .res_cycles      (res_cycles),
    .res_timeout     (res_timeout),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Count every job handshake the sequencer takes
  always @(posedge clk) begin
    if (!rst && job_valid && job_ready) accept_cnt <= accept_cnt + 1;
  end

  // Offer a job (called at a negedge) and return at the first RUN negedge
  task automatic offer_job(input logic [6:0] fp, input logic [PW-1:0] fv, input bit hold_valid,
                           output bit accepted, output int pulse);
    job_firstpos    = fp;
    job_firstvalues = fv;
    job_valid       = 1'b1;
    accepted        = 1'b0;
    pulse           = 0;
    for (int i = 0; i < 50; i++) begin
      if (job_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      job_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold_valid) job_valid = 1'b0;
    while (assy_reset && pulse < 20) begin
      pulse++;
      @(negedge clk);
    end
  endtask

  // Raise done so the k-th RUN edge samples it; report res_valid one cycle later
  task automatic run_for(input int k, input logic [5:0] n, input logic [RW-1:0] r, output bit seen);
    for (int i = 1; i < k; i++) @(negedge clk);
    assy_done       = 1'b1;
    assy_numResults = n;
    assy_results    = r;
    @(negedge clk);
    seen            = res_valid;
    assy_done       = 1'b0;
    assy_numResults = 6'h3F;
    assy_results    = ~r;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    job_valid       = 1'b0;
    job_firstpos    = '0;
    job_firstvalues = '0;
    assy_done       = 1'b0;
    assy_numResults = '0;
    assy_results    = '0;
    res_ready       = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (job_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_job_ready: got %0b expected 0", job_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_valid: got %0b expected 0", res_valid); end
    vectors++; if (res_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_timeout: got %0b expected 0", res_timeout); end
    vectors++; if (assy_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_assy_reset: got %0b expected 1", assy_reset); end
    vectors++; if (res_jobid !== 8'd0 || res_numResults !== 6'd0 || res_cycles !== 32'd0)
      begin miscompares++; $display("[TB] FAIL reset_res_fields: got jobid=%0d n=%0d cyc=%0d expected 0/0/0", res_jobid, res_numResults, res_cycles); end
    vectors++; if (res_results !== '0 || assy_firstpos !== 7'd0 || assy_firstvalues !== '0)
      begin miscompares++; $display("[TB] FAIL reset_data_zero: got fp=%0d fv=%0h expected zeros", assy_firstpos, assy_firstvalues); end
    rst = 1'b0;
    #1;
    vectors++; if (job_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_job_ready: got %0b expected 1", job_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_job();
    bit acc;
    bit seen;
    int pulse;
    offer_job(7'd1, '0, 1'b0, acc, pulse);
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("[TB] FAIL single_accept: got %0b expected 1", acc); end
    vectors++; if (pulse !== 2) begin miscompares++; $display("[TB] FAIL single_reset_pulse: got %0d expected 2", pulse); end
    vectors++; if (assy_firstpos !== 7'd1 || assy_firstvalues !== '0)
      begin miscompares++; $display("[TB] FAIL single_prefix: got fp=%0d fv=%0h expected 1/0", assy_firstpos, assy_firstvalues); end
    run_for(100, 6'd2, PAT_A, seen);
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL single_res_valid: got %0b expected 1", seen); end
    vectors++; if (res_jobid !== 8'd0) begin miscompares++; $display("[TB] FAIL single_jobid: got %0d expected 0", res_jobid); end
    vectors++; if (res_numResults !== 6'd2) begin miscompares++; $display("[TB] FAIL single_numResults: got %0d expected 2", res_numResults); end
    vectors++; if (res_cycles !== 32'd100) begin miscompares++; $display("[TB] FAIL single_cycles: got %0d expected 100", res_cycles); end
    vectors++; if (res_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL single_timeout: got %0b expected 0", res_timeout); end
    vectors++; if (res_results !== PAT_A) begin miscompares++; $display("[TB] FAIL single_results: got %0h expected %0h", res_results, PAT_A); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0)
      begin miscompares++; $display("[TB] FAIL single_after_handshake: got valid=%0b ready=%0b busy=%0b expected 0/1/0", res_valid, job_ready, busy); end
    vectors++; if (res_numResults !== 6'd2 || res_cycles !== 32'd100)
      begin miscompares++; $display("[TB] FAIL single_record_held: got n=%0d cyc=%0d expected 2/100", res_numResults, res_cycles); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    bit seen;
    int pulse;
    int base;
    base      = accept_cnt;
    res_ready = 1'b1;
    offer_job(7'd2, FV_B, 1'b1, acc, pulse);
    vectors++; if (acc !== 1'b1 || pulse !== 2) begin miscompares++; $display("[TB] FAIL b2b_first_accept: got acc=%0b pulse=%0d expected 1/2", acc, pulse); end
    vectors++; if (assy_firstpos !== 7'd2 || assy_firstvalues !== FV_B)
      begin miscompares++; $display("[TB] FAIL b2b_first_prefix: got fp=%0d fv=%0h expected 2/%0h", assy_firstpos, assy_firstvalues, FV_B); end
    run_for(3, 6'd1, PAT_B, seen);
    vectors++; if (seen !== 1'b1 || res_jobid !== 8'd1 || res_cycles !== 32'd3 || res_numResults !== 6'd1)
      begin miscompares++; $display("[TB] FAIL b2b_first_record: got v=%0b id=%0d cyc=%0d n=%0d expected 1/1/3/1", seen, res_jobid, res_cycles, res_numResults); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0 || job_ready !== 1'b1)
      begin miscompares++; $display("[TB] FAIL b2b_idle_between: got valid=%0b ready=%0b expected 0/1", res_valid, job_ready); end
    offer_job(7'd3, FV_C, 1'b1, acc, pulse);
    vectors++; if (acc !== 1'b1 || pulse !== 2) begin miscompares++; $display("[TB] FAIL b2b_second_accept: got acc=%0b pulse=%0d expected 1/2", acc, pulse); end
    vectors++; if (assy_firstpos !== 7'd3 || assy_firstvalues !== FV_C)
      begin miscompares++; $display("[TB] FAIL b2b_second_prefix: got fp=%0d fv=%0h expected 3/%0h", assy_firstpos, assy_firstvalues, FV_C); end
    run_for(4, 6'd5, PAT_C, seen);
    job_valid = 1'b0;
    vectors++; if (seen !== 1'b1 || res_jobid !== 8'd2 || res_cycles !== 32'd4 || res_results !== PAT_C)
      begin miscompares++; $display("[TB] FAIL b2b_second_record: got v=%0b id=%0d cyc=%0d expected 1/2/4", seen, res_jobid, res_cycles); end
    repeat (6) @(negedge clk);
    vectors++; if (accept_cnt - base !== 2) begin miscompares++; $display("[TB] FAIL b2b_accept_count: got %0d expected 2", accept_cnt - base); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_final_busy: got %0b expected 0", busy); end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit acc;
    bit seen;
    int pulse;
    offer_job(7'd4, FV_D, 1'b0, acc, pulse);
    run_for(5, 6'd7, PAT_D, seen);
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_res_valid: got %0b expected 1", seen); end
    job_valid    = 1'b1;
    job_firstpos = 7'd9;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b1 || res_jobid !== 8'd3 || res_numResults !== 6'd7 || res_cycles !== 32'd5 ||
          res_results !== PAT_D || job_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold_%0d: got v=%0b id=%0d n=%0d cyc=%0d rdy=%0b busy=%0b expected 1/3/7/5/0/1",
                 i, res_valid, res_jobid, res_numResults, res_cycles, job_ready, busy);
      end
    end
    job_valid = 1'b0;
    vectors++; if (assy_firstpos !== 7'd4) begin miscompares++; $display("[TB] FAIL bp_prefix_held: got %0d expected 4", assy_firstpos); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0 || job_ready !== 1'b1 || res_jobid !== 8'd3)
      begin miscompares++; $display("[TB] FAIL bp_release: got v=%0b rdy=%0b id=%0d expected 0/1/3", res_valid, job_ready, res_jobid); end
  endtask

`ifdef GOLOMB_WATCHDOG_EN
  task automatic test_watchdog();
    bit acc;
    bit seen;
    int pulse;
    offer_job(7'd1, '0, 1'b0, acc, pulse);
    assy_results    = PAT_E;
    assy_numResults = 6'd9;
    seen            = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL wd_record: got %0b expected 1", seen); end
    vectors++; if (res_timeout !== 1'b1 || res_numResults !== 6'd0 || res_cycles !== 32'd64)
      begin miscompares++; $display("[TB] FAIL wd_fields: got to=%0b n=%0d cyc=%0d expected 1/0/64", res_timeout, res_numResults, res_cycles); end
    vectors++; if (res_results !== PAT_E || res_jobid !== 8'd4)
      begin miscompares++; $display("[TB] FAIL wd_snapshot: got id=%0d res=%0h expected 4/%0h", res_jobid, res_results, PAT_E); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    offer_job(7'd1, '0, 1'b0, acc, pulse);
    run_for(64, 6'd3, PAT_F, seen);
    vectors++; if (seen !== 1'b1 || res_timeout !== 1'b0 || res_numResults !== 6'd3 || res_cycles !== 32'd64)
      begin miscompares++; $display("[TB] FAIL wd_done_wins: got v=%0b to=%0b n=%0d cyc=%0d expected 1/0/3/64", seen, res_timeout, res_numResults, res_cycles); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_run();
    bit acc;
    bit seen;
    int pulse;
    offer_job(7'd2, FV_B, 1'b0, acc, pulse);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || assy_reset !== 1'b1 || res_valid !== 1'b0 || job_ready !== 1'b0)
      begin miscompares++; $display("[TB] FAIL midrst_outputs: got busy=%0b ar=%0b v=%0b rdy=%0b expected 0/1/0/0", busy, assy_reset, res_valid, job_ready); end
    assy_done = 1'b1;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0 || res_numResults !== 6'd0 || res_cycles !== 32'd0)
      begin miscompares++; $display("[TB] FAIL midrst_no_record: got v=%0b n=%0d cyc=%0d expected 0/0/0", res_valid, res_numResults, res_cycles); end
    assy_done = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1)
      begin miscompares++; $display("[TB] FAIL midrst_release: got v=%0b busy=%0b rdy=%0b expected 0/0/1", res_valid, busy, job_ready); end
    offer_job(7'd1, '0, 1'b0, acc, pulse);
    run_for(10, 6'd4, PAT_A, seen);
    vectors++; if (seen !== 1'b1 || res_jobid !== 8'd0 || res_cycles !== 32'd10 || res_numResults !== 6'd4)
      begin miscompares++; $display("[TB] FAIL midrst_next_job: got v=%0b id=%0d cyc=%0d n=%0d expected 1/0/10/4", seen, res_jobid, res_cycles, res_numResults); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_backpressure();
`ifdef GOLOMB_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got still running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/golomb_job_sequencer.md
# golomb_job_sequencer

Sequences one `mark_counter_assembly` instance through a stream of sub-search jobs handed down by the host. Each job is a preset ruler prefix: a `firstvariableposition` plus a `firstvalues` vector. For every job the block:
- loads the prefix and holds the assembly in reset;
- releases it and waits for `done`;
- captures `numResults`/`results`, tags them with a job id and run-cycle count, and returns them through a valid/ready result port.

It sits between the host/USB interface logic and the search datapath, and is the only driver of the assembly's reset and prefix inputs.

## Interface
Parameters:
- MAXVALUE, 22, maximal ruler length (passed through for width checks only)
- NUMPOSITIONS, 5, index of last mark; prefix width is (NUMPOSITIONS+1)*9 bits
- NUMRESULTS, 10, result slots in the assembly
- ASSY_RESET_CYCLES, 2, cycles assy_reset is held high per job (≥1)
- WATCHDOG_CYCLES, 32'd1000000, RUN-state cycle limit (used only with watchdog compiled in)

Ports:
- FXCLK  in  1  clock from board; one clock domain. Reset is asynchronous and active-high.
- RESET_IN  in  1  asynchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  sequencer accepts job
- job_firstpos  in  7  first variable mark index
- job_firstvalues  in  (NUMPOSITIONS+1)*9  preset mark positions
- assy_reset  out  1  drives the assembly's RESET_IN
- assy_firstpos  out  7  registered copy of job_firstpos
- assy_firstvalues  out  (NUMPOSITIONS+1)*9  registered copy of job_firstvalues
- assy_done  in  1  assembly's done
- assy_numResults  in  6  assembly's result count
- assy_results  in  (NUMPOSITIONS+1)*9*NUMRESULTS  assembly's result vector
- res_valid  out  1  result record available
- res_ready  in  1  consumer takes record
- res_jobid  out  8  tag of the job this record belongs to
- res_numResults  out  6  captured count
- res_results  out  (NUMPOSITIONS+1)*9*NUMRESULTS  captured results
- res_cycles  out  32  RUN-state cycles, saturating at 32'hFFFFFFFF
- res_timeout  out  1  record produced by watchdog, not by done
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, REPORT.
- IDLE:
  - job_ready=1.
  - On job_valid&&job_ready: register firstpos/firstvalues; clear cycle counter; go to LOAD.
- LOAD:
  - assy_reset=1 for exactly ASSY_RESET_CYCLES cycles, then go to RUN.
  - assy_done is ignored in LOAD. The assembly clears done under its reset (integration contract).
- RUN:
  - assy_reset=0; cycle counter increments each cycle.
  - When assy_done=1: capture assy_numResults/assy_results into result registers; res_timeout=0; go to REPORT.
- REPORT:
  - res_valid=1; outputs stay stable until res_ready.
  - On res_valid&&res_ready: jobid increments (mod 256); go to IDLE.
- No back-to-back bypass: IDLE is always visited between jobs.
- assy_firstpos/assy_firstvalues hold the last accepted job until the next acceptance.
- res_* registers hold the last record after the handshake; only res_valid drops.

## Timing
- Reset values:
  - job_ready=0 while RESET_IN high; 1 on the first cycle after release.
  - busy=0, res_valid=0, res_timeout=0, assy_reset=1 (assembly held in reset during block reset).
  - All data outputs 0; jobid=0.
- Job acceptance at edge N → assy_reset high from N+1 through N+ASSY_RESET_CYCLES → RUN from N+ASSY_RESET_CYCLES+1.
- assy_done sampled high at edge M in RUN → res_valid high from M+1. res_cycles counts RUN cycles up to and including M.
- res_ready high with res_valid at edge K → res_valid=0 and job_ready=1 from K+1.
- res_ready asserted before res_valid has no effect.
- RESET_IN mid-job: the job is dropped with no record emitted, and the assembly is held in reset.

## Configuration
- GOLOMB_WATCHDOG_EN defined:
  - In RUN, when the cycle counter reaches WATCHDOG_CYCLES without done, go to REPORT with res_timeout=1 and res_numResults=0.
  - res_results holds the assembly's current assy_results snapshot.
  - If done and the watchdog limit fall in the same cycle, done wins (res_timeout=0).
- GOLOMB_WATCHDOG_EN undefined:
  - No timeout; RUN waits indefinitely; res_timeout is tied to 0.
  - WATCHDOG_CYCLES is unused.

## Structure
- Shared package golomb_pkg:
  - MARK_W=9, POS_W=7, NRES_W=6, JOBID_W=8, CYC_W=32;
  - the sequencer state enum (IDLE/LOAD/RUN/REPORT);
  - a width function for prefix and result vectors from NUMPOSITIONS/NUMRESULTS.
- One natural sub-module, golomb_cycle_counter: saturating CYC_W counter with clear/enable and a terminal-count compare used by the watchdog.

## Test plan
- Single job: firstpos=1, firstvalues=0, stub done after 100 RUN cycles with numResults=2 → one record, jobid=0, res_numResults=2, res_cycles=100, res_timeout=0.
- Two queued jobs with job_valid held high → exactly two acceptances, separated by REPORT/IDLE; jobids 0 then 1; assy_reset pulse length ASSY_RESET_CYCLES each time.
- Result backpressure: hold res_ready low 50 cycles → res_valid and all res_* stable; job_ready stays 0 until the handshake.
- Watchdog: GOLOMB_WATCHDOG_EN defined, WATCHDOG_CYCLES=64, done never asserted → record after 64 RUN cycles with res_timeout=1 and res_numResults=0. With done on cycle 64 as well → res_timeout=0.
- Reset mid-RUN → no res_valid; busy=0 and assy_reset=1 during reset. The next job after release gets jobid=0.
- Full integration with the real mark_counter_assembly: NUMPOSITIONS=5, MAXVALUE=22, firstpos=1 → res_numResults≥1 and the captured ruler has last mark 17 (optimal 6-mark ruler).
